// File: rtl/serial_to_parallel.sv
`default_nettype none
// ----------------------------------------------------------------------------
// serial_to_parallel - collects up to Length N-bit words into a parallel bank
// and holds done_o until the consumer acknowledges.            Rev 1.0
// ----------------------------------------------------------------------------
module serial_to_parallel #(
   parameter int N      = 8,
   parameter int Length = 3,
   localparam int CW    = $clog2(Length + 1)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          srst_i,
   input  logic          start_i,
   input  logic [CW-1:0] word_count_i,
   input  logic          valid_i,
   input  logic [N-1:0]  data_i,
   output logic          ready_o,
   output logic [N-1:0]  data_o [Length-1:0],
   output logic [CW-1:0] count_o,
   output logic          done_o,
   input  logic          ack_i,
   input  logic          assert_on_i
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      FULL    = 2'd2
   } state_t;

   state_t        state;
   logic [CW-1:0] eff;
   logic [CW-1:0] wc_clamped;
   logic [CW-1:0] count_next;
   logic [CW:0]   wc_wide;
   logic          over;
   logic          launch;

   // Widened by one bit so the bound check is meaningful for any Length.
   assign wc_wide    = {1'b0, word_count_i};
   assign over       = wc_wide > (CW + 1)'(Length);
   assign wc_clamped = over ? CW'(Length) : word_count_i;
   assign count_next = count_o + CW'(1);
   assign launch     = start_i && ((state == IDLE) || ((state == FULL) && ack_i));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state   <= IDLE;
         eff     <= '0;
         count_o <= '0;
         ready_o <= 1'b0;
         done_o  <= 1'b0;
         for (int i = 0; i < Length; i++) data_o[i] <= '0;
      end else if (srst_i) begin
         state   <= IDLE;
         eff     <= '0;
         count_o <= '0;
         ready_o <= 1'b0;
         done_o  <= 1'b0;
         for (int i = 0; i < Length; i++) data_o[i] <= '0;
      end else if (launch) begin
         eff     <= wc_clamped;
         count_o <= '0;
         for (int i = 0; i < Length; i++) data_o[i] <= '0;
         if (wc_clamped == '0) begin
            state   <= FULL;
            ready_o <= 1'b0;
            done_o  <= 1'b1;
         end else begin
            state   <= COLLECT;
            ready_o <= 1'b1;
            done_o  <= 1'b0;
         end
      end else begin
         case (state)
            COLLECT: begin
               if (valid_i) begin
                  for (int i = 0; i < Length; i++) begin
                     if (count_o == CW'(i)) data_o[i] <= data_i;
                  end
                  count_o <= count_next;
                  if (count_next == eff) begin
                     state   <= FULL;
                     ready_o <= 1'b0;
                     done_o  <= 1'b1;
                  end
               end
            end
            FULL: begin
               if (ack_i) begin
                  state  <= IDLE;
                  done_o <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk_i) begin
      if (rst_ni && !srst_i && assert_on_i) begin
         if (launch) begin
            assert (!over)
               else $error("serial_to_parallel: word_count_i=%0d exceeds Length=%0d", word_count_i, Length);
         end
         assert (!(valid_i && (state != COLLECT)))
            else $error("serial_to_parallel: valid_i outside COLLECT, word dropped");
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_to_parallel.sv
`default_nettype none
// tb_serial_to_parallel - directed and randomized checks against a queue-based
// frame model; a second Length=2 instance covers count clamping.
module tb_serial_to_parallel;

   localparam int L = 3;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic       srst_i = 1'b0;
   logic       start_i = 1'b0;
   logic [1:0] word_count_i = '0;
   logic       valid_i = 1'b0;
   logic [7:0] data_i = '0;
   logic       ready_o;
   logic [7:0] data_o [2:0];
   logic [1:0] count_o;
   logic       done_o;
   logic       ack_i = 1'b0;
   logic       assert_on_i = 1'b1;

   logic       s2_start = 1'b0;
   logic [1:0] s2_wc = '0;
   logic       s2_valid = 1'b0;
   logic [7:0] s2_data = '0;
   logic       s2_ack = 1'b0;
   logic       s2_ready;
   logic [7:0] s2_dout [1:0];
   logic [1:0] s2_count;
   logic       s2_done;

   int checks = 0;
   int errors = 0;

   // Frame-level reference: words received so far, requested size, status.
   logic [7:0] m_words [$];
   int         m_target = 0;
   bit         m_active = 0;
   bit         m_done = 0;

   serial_to_parallel #(.N(8), .Length(L)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .srst_i(srst_i), .start_i(start_i),
      .word_count_i(word_count_i), .valid_i(valid_i), .data_i(data_i),
      .ready_o(ready_o), .data_o(data_o), .count_o(count_o), .done_o(done_o),
      .ack_i(ack_i), .assert_on_i(assert_on_i)
   );

   serial_to_parallel #(.N(8), .Length(2)) dut2 (
      .clk_i(clk_i), .rst_ni(rst_ni), .srst_i(1'b0), .start_i(s2_start),
      .word_count_i(s2_wc), .valid_i(s2_valid), .data_i(s2_data),
      .ready_o(s2_ready), .data_o(s2_dout), .count_o(s2_count), .done_o(s2_done),
      .ack_i(s2_ack), .assert_on_i(1'b0)
   );

   initial forever #5 clk_i = ~clk_i;

   task automatic model_clear();
      m_words.delete();
      m_target = 0;
      m_active = 0;
      m_done   = 0;
   endtask

   task automatic model_step();
      if (srst_i) begin
         model_clear();
      end else if (start_i && !m_active && (!m_done || ack_i)) begin
         m_target = (int'(word_count_i) > L) ? L : int'(word_count_i);
         m_words.delete();
         m_done   = (m_target == 0);
         m_active = !m_done;
      end else if (m_active) begin
         if (valid_i) begin
            m_words.push_back(data_i);
            if (m_words.size() == m_target) begin
               m_active = 0;
               m_done   = 1;
            end
         end
      end else if (m_done && ack_i) begin
         m_done = 0;
      end
   endtask

   function automatic logic [7:0] exp_word(int i);
      return (i < m_words.size()) ? m_words[i] : 8'h00;
   endfunction

   task automatic tick();
      model_step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      start_i = 0; valid_i = 0; ack_i = 0; srst_i = 0; data_i = '0; word_count_i = '0;
   endtask

   task automatic test_reset();
      checks++;
      if (ready_o !== 1'b0 || done_o !== 1'b0 || count_o !== 2'd0) begin
         errors++;
         $display("FAIL reset_ctrl got ready=%b done=%b count=%0d want 0 0 0", ready_o, done_o, count_o);
      end
      for (int i = 0; i < L; i++) begin
         checks++;
         if (data_o[i] !== 8'h00) begin
            errors++;
            $display("FAIL reset_data[%0d] got %h want 00", i, data_o[i]);
         end
      end
   endtask

   task automatic test_basic();
      logic [7:0] beats [3] = '{8'hA1, 8'hB2, 8'hC3};
      start_i = 1; word_count_i = 2'd3; tick(); start_i = 0;
      checks++;
      if (ready_o !== 1'b1) begin errors++; $display("FAIL basic_ready got %b want 1", ready_o); end
      for (int b = 0; b < 3; b++) begin
         valid_i = 1; data_i = beats[b]; tick();
      end
      valid_i = 0;
      checks++;
      if (done_o !== 1'b1 || ready_o !== 1'b0 || count_o !== 2'd3) begin
         errors++;
         $display("FAIL basic_ctrl got done=%b ready=%b count=%0d want 1 0 3", done_o, ready_o, count_o);
      end
      for (int i = 0; i < L; i++) begin
         checks++;
         if (data_o[i] !== beats[i] || data_o[i] !== exp_word(i)) begin
            errors++;
            $display("FAIL basic_data[%0d] got %h want %h", i, data_o[i], beats[i]);
         end
      end
      ack_i = 1; tick(); ack_i = 0;
   endtask

   task automatic test_gap_and_hold();
      logic [7:0] snap [3];
      start_i = 1; word_count_i = 2'd2; tick(); start_i = 0;
      valid_i = 1; data_i = 8'h11; tick(); valid_i = 0;
      tick(); tick();
      checks++;
      if (done_o !== 1'b0 || count_o !== 2'd1) begin
         errors++;
         $display("FAIL gap_wait got done=%b count=%0d want 0 1", done_o, count_o);
      end
      valid_i = 1; data_i = 8'h22; tick(); valid_i = 0;
      checks++;
      if (done_o !== 1'b1 || count_o !== 2'd2 || data_o[0] !== 8'h11 || data_o[1] !== 8'h22 || data_o[2] !== 8'h00) begin
         errors++;
         $display("FAIL gap_done got done=%b count=%0d data=%h_%h_%h want 1 2 00_22_11",
                  done_o, count_o, data_o[2], data_o[1], data_o[0]);
      end
      for (int i = 0; i < L; i++) snap[i] = data_o[i];
      assert_on_i = 0;
      for (int c = 0; c < 4; c++) begin
         valid_i = 1; data_i = 8'hFF; tick();
         checks++;
         if (done_o !== 1'b1 || count_o !== 2'd2 || data_o[0] !== snap[0] || data_o[1] !== snap[1] || data_o[2] !== snap[2]) begin
            errors++;
            $display("FAIL full_hold cycle %0d got done=%b count=%0d data=%h_%h_%h want 1 2 %h_%h_%h", c,
                     done_o, count_o, data_o[2], data_o[1], data_o[0], snap[2], snap[1], snap[0]);
         end
      end
      valid_i = 0; assert_on_i = 1;
      ack_i = 1; tick(); ack_i = 0;
      checks++;
      if (done_o !== 1'b0 || ready_o !== 1'b0) begin
         errors++;
         $display("FAIL full_ack got done=%b ready=%b want 0 0", done_o, ready_o);
      end
   endtask

   task automatic test_back_to_back();
      start_i = 1; word_count_i = 2'd1; tick(); start_i = 0;
      valid_i = 1; data_i = 8'h77; tick(); valid_i = 0;
      ack_i = 1; start_i = 1; word_count_i = 2'd1; tick(); ack_i = 0; start_i = 0;
      checks++;
      if (done_o !== 1'b0 || ready_o !== 1'b1 || count_o !== 2'd0 || data_o[0] !== 8'h00) begin
         errors++;
         $display("FAIL b2b_restart got done=%b ready=%b count=%0d d0=%h want 0 1 0 00",
                  done_o, ready_o, count_o, data_o[0]);
      end
      valid_i = 1; data_i = 8'h5A; tick(); valid_i = 0;
      checks++;
      if (done_o !== 1'b1 || data_o[0] !== 8'h5A || data_o[1] !== 8'h00 || data_o[0] !== exp_word(0)) begin
         errors++;
         $display("FAIL b2b_done got done=%b d0=%h d1=%h want 1 5a 00", done_o, data_o[0], data_o[1]);
      end
      ack_i = 1; tick(); ack_i = 0;
   endtask

   task automatic test_zero_and_clamp();
      start_i = 1; word_count_i = 2'd0; tick(); start_i = 0;
      checks++;
      if (done_o !== 1'b1 || ready_o !== 1'b0 || count_o !== 2'd0 || data_o[0] !== 8'h00 || data_o[2] !== 8'h00) begin
         errors++;
         $display("FAIL zero_count got done=%b ready=%b count=%0d want 1 0 0", done_o, ready_o, count_o);
      end
      ack_i = 1; tick(); ack_i = 0;
      s2_start = 1; s2_wc = 2'd3; tick(); s2_start = 0;
      s2_valid = 1; s2_data = 8'h3C; tick();
      checks++;
      if (s2_done !== 1'b0 || s2_ready !== 1'b1) begin
         errors++;
         $display("FAIL clamp_mid got done=%b ready=%b want 0 1", s2_done, s2_ready);
      end
      s2_data = 8'hD4; tick(); s2_valid = 0;
      checks++;
      if (s2_done !== 1'b1 || s2_count !== 2'd2 || s2_dout[0] !== 8'h3C || s2_dout[1] !== 8'hD4) begin
         errors++;
         $display("FAIL clamp_done got done=%b count=%0d data=%h_%h want 1 2 d4_3c",
                  s2_done, s2_count, s2_dout[1], s2_dout[0]);
      end
      s2_ack = 1; tick(); s2_ack = 0;
   endtask

   task automatic test_async_reset();
      start_i = 1; word_count_i = 2'd3; tick(); start_i = 0;
      valid_i = 1; data_i = 8'h33; tick(); valid_i = 0;
      #2 rst_ni = 0;
      #1;
      model_clear();
      checks++;
      if (count_o !== 2'd0 || ready_o !== 1'b0 || done_o !== 1'b0 || data_o[0] !== 8'h00) begin
         errors++;
         $display("FAIL async_reset got count=%0d ready=%b done=%b d0=%h want 0 0 0 00",
                  count_o, ready_o, done_o, data_o[0]);
      end
      #1 rst_ni = 1;
      assert_on_i = 0;
      for (int c = 0; c < 2; c++) begin
         valid_i = 1; data_i = 8'h44 + 8'(c); tick();
      end
      valid_i = 0; assert_on_i = 1;
      checks++;
      if (count_o !== 2'd0 || ready_o !== 1'b0 || done_o !== 1'b0 || data_o[0] !== 8'h00) begin
         errors++;
         $display("FAIL post_reset_ignore got count=%0d ready=%b done=%b d0=%h want 0 0 0 00",
                  count_o, ready_o, done_o, data_o[0]);
      end
   endtask

   task automatic test_random();
      assert_on_i = 0;
      for (int c = 0; c < 400; c++) begin
         srst_i       = ($urandom_range(0, 59) == 0);
         start_i      = ($urandom_range(0, 3) == 0);
         word_count_i = 2'($urandom_range(0, 3));
         valid_i      = ($urandom_range(0, 2) != 0);
         data_i       = 8'($urandom);
         ack_i        = ($urandom_range(0, 2) == 0);
         tick();
         checks++;
         if (ready_o !== m_active || done_o !== m_done || count_o !== 2'(m_words.size())) begin
            errors++;
            $display("FAIL rand_ctrl cycle %0d got ready=%b done=%b count=%0d want %b %b %0d",
                     c, ready_o, done_o, count_o, m_active, m_done, m_words.size());
         end
         for (int i = 0; i < L; i++) begin
            checks++;
            if (data_o[i] !== exp_word(i)) begin
               errors++;
               $display("FAIL rand_data[%0d] cycle %0d got %h want %h", i, c, data_o[i], exp_word(i));
            end
         end
      end
      idle_inputs();
      srst_i = 1; tick(); srst_i = 0;
      assert_on_i = 1;
   endtask

   initial begin
      model_clear();
      repeat (3) @(posedge clk_i);
      #1 rst_ni = 1;
      test_reset();
      test_basic();
      test_gap_and_hold();
      test_back_to_back();
      test_zero_and_clamp();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
